alpha_operand_streamer: RTL and testbench

- Producer side of the Levinson-Durbin alpha interface: holds the autocorrelation vector ACF[0..ORDER] and the current model coefficients model[0..ORDER] (IEEE-754 single).
- On a start request for order m, streams operand pairs in the beat format the alpha calculator consumes, two products per beat, then waits for the calculator's done.
- Sits between the ACF/model update logic and the alpha calculator in the LPC coefficient path of the hardware encoder.

---
 rtl/lpc_pkg.sv | 23 ++
 rtl/coeff_regfile.sv | 32 +++
 rtl/alpha_operand_streamer.sv | 158 +++++++++++++++
 tb/tb_alpha_operand_streamer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpc_pkg.sv
// Shared definitions for the LPC coefficient path: dimensions, FSM encodings,
// IEEE-754 constants and the beat-count helper used by the alpha operand streamer.
package lpc_pkg;

  localparam int ORDER     = 12;
  localparam int MAX_BEATS = 6;
  localparam int DATA_W    = 32;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;

  localparam logic [31:0] FP_ONE  = 32'h3f80_0000;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  // Two products per beat, so an order-m request needs ceil(m/2) beats.
  function automatic logic [3:0] beats_for_order(input logic [3:0] m);
    logic [4:0] t;
    t = {1'b0, m} + 5'd1;
    return t[4:1];
  endfunction

endpackage

// File: rtl/coeff_regfile.sv
// Small coefficient store: one synchronous write port, two combinational read
// ports. Out-of-range writes are dropped and out-of-range reads return zero.
module coeff_regfile #(
  parameter int DEPTH = 13,
  parameter int W     = 32,
  parameter int AW    = 4
) (
  input  logic          iClock,
  input  logic          iReset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [W-1:0]  rdata_a,
  output logic [W-1:0]  rdata_b
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge iClock) begin
    if (iReset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we && (int'(waddr) < DEPTH)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = (int'(raddr_a) < DEPTH) ? mem[raddr_a] : '0;
  assign rdata_b = (int'(raddr_b) < DEPTH) ? mem[raddr_b] : '0;

endmodule

// File: rtl/alpha_operand_streamer.sv
// Producer side of the Levinson-Durbin alpha interface: holds ACF and model
// coefficients and streams operand pairs, two products per beat, per request.
module alpha_operand_streamer #(
  parameter int ORDER     = lpc_pkg::ORDER,
  parameter int MAX_BEATS = lpc_pkg::MAX_BEATS,
  parameter int DATA_W    = lpc_pkg::DATA_W
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iEnable,
  input  logic              iACFWrite,
  input  logic [3:0]        iACFAddr,
  input  logic [DATA_W-1:0] iACFData,
  input  logic              iModelWrite,
  input  logic [3:0]        iModelAddr,
  input  logic [DATA_W-1:0] iModelData,
  input  logic              iStart,
  input  logic [3:0]        iM,
  input  logic              iAlphaDone,
  output logic              oValid,
  output logic [DATA_W-1:0] oACF1,
  output logic [DATA_W-1:0] oACF2,
  output logic [DATA_W-1:0] oModel1,
  output logic [DATA_W-1:0] oModel2,
  output logic [3:0]        oM,
  output logic              oBusy,
  output logic              oStreamDone,
  output logic              oError
);
  import lpc_pkg::*;

  localparam int         KW      = $clog2(MAX_BEATS + 1);
  localparam logic [3:0] ORDER_L = 4'(ORDER);

  // Interface contract: oValid qualifies one beat per enabled cycle with no
  // back-pressure; the consumer must take every beat. After the last beat the
  // streamer waits for iAlphaDone before accepting another iStart.

  logic [1:0]        state;
  logic [KW-1:0]     k;
  logic [3:0]        cur_m;
  logic [KW-1:0]     cur_k;
  logic [3:0]        two_k;
  logic [3:0]        beats;
  logic              has_pair;
  logic              m_legal;
  logic              acf_we;
  logic              model_we;
  logic [3:0]        model_ra, model_rb, acf_ra, acf_rb;
  logic [DATA_W-1:0] model_rd_a, model_rd_b, acf_rd_a, acf_rd_b;

  // In S_IDLE the first beat is formed directly from iM so it can be
  // registered on the same edge that accepts the start.
  assign cur_m    = (state == S_IDLE) ? iM : oM;
  assign cur_k    = (state == S_IDLE) ? '0 : k;
  assign two_k    = 4'({cur_k, 1'b0});
  assign model_ra = two_k;
  assign model_rb = two_k + 4'd1;
  assign acf_ra   = cur_m - two_k;
  assign acf_rb   = cur_m - two_k - 4'd1;
  assign has_pair = (two_k + 4'd1) < cur_m;
  assign beats    = beats_for_order(oM);
  assign m_legal  = (iM != 4'd0) && (iM <= ORDER_L);

  assign acf_we   = iEnable && iACFWrite   && (state != S_STREAM);
  assign model_we = iEnable && iModelWrite && (state != S_STREAM);

  coeff_regfile #(.DEPTH(ORDER + 1), .W(DATA_W), .AW(4)) u_acf (
    .iClock  (iClock),
    .iReset  (iReset),
    .we      (acf_we),
    .waddr   (iACFAddr),
    .wdata   (iACFData),
    .raddr_a (acf_ra),
    .raddr_b (acf_rb),
    .rdata_a (acf_rd_a),
    .rdata_b (acf_rd_b)
  );

  coeff_regfile #(.DEPTH(ORDER + 1), .W(DATA_W), .AW(4)) u_model (
    .iClock  (iClock),
    .iReset  (iReset),
    .we      (model_we),
    .waddr   (iModelAddr),
    .wdata   (iModelData),
    .raddr_a (model_ra),
    .raddr_b (model_rb),
    .rdata_a (model_rd_a),
    .rdata_b (model_rd_b)
  );

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state       <= S_IDLE;
      k           <= '0;
      oValid      <= 1'b0;
      oACF1       <= '0;
      oACF2       <= '0;
      oModel1     <= '0;
      oModel2     <= '0;
      oM          <= '0;
      oBusy       <= 1'b0;
      oStreamDone <= 1'b0;
      oError      <= 1'b0;
    end else if (iEnable) begin
      oValid      <= 1'b0;
      oACF1       <= '0;
      oACF2       <= '0;
      oModel1     <= '0;
      oModel2     <= '0;
      oStreamDone <= 1'b0;
      oError      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (iStart) begin
            if (m_legal) begin
              oM      <= iM;
              state   <= S_STREAM;
              oBusy   <= 1'b1;
              k       <= KW'(1);
              oValid  <= 1'b1;
              oModel1 <= model_rd_a;
              oACF2   <= acf_rd_a;
              oModel2 <= has_pair ? model_rd_b : FP_ZERO;
              oACF1   <= has_pair ? acf_rd_b   : FP_ZERO;
            end else begin
              oError <= 1'b1;
            end
          end
        end
        S_STREAM: begin
          if (4'(k) == beats) begin
            state       <= S_WAIT;
            oStreamDone <= 1'b1;
          end else begin
            k       <= k + KW'(1);
            oValid  <= 1'b1;
            oModel1 <= model_rd_a;
            oACF2   <= acf_rd_a;
            oModel2 <= has_pair ? model_rd_b : FP_ZERO;
            oACF1   <= has_pair ? acf_rd_b   : FP_ZERO;
          end
        end
        S_WAIT: begin
          if (iAlphaDone) begin
            state <= S_IDLE;
            oBusy <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          oBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alpha_operand_streamer.sv
// Directed table-driven bench for alpha_operand_streamer: beat contents, beat
// counts, error pulses, stalls, ignored starts/writes and mid-stream reset.
module tb_alpha_operand_streamer;

  logic        iClock = 1'b0;
  logic        iReset;
  logic        iEnable;
  logic        iACFWrite;
  logic [3:0]  iACFAddr;
  logic [31:0] iACFData;
  logic        iModelWrite;
  logic [3:0]  iModelAddr;
  logic [31:0] iModelData;
  logic        iStart;
  logic [3:0]  iM;
  logic        iAlphaDone;
  logic        oValid;
  logic [31:0] oACF1, oACF2, oModel1, oModel2;
  logic [3:0]  oM;
  logic        oBusy, oStreamDone, oError;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] m1;
    logic [31:0] a2;
    logic [31:0] m2;
    logic [31:0] a1;
  } beat_t;

  typedef struct {
    logic [3:0] m;
    int         nb;
    int         poke;
    int         stall;
  } stream_t;

  logic [127:0] exp_q[$];
  beat_t        vecs[17];
  stream_t      streams[6];

  alpha_operand_streamer dut (
    .iClock      (iClock),
    .iReset      (iReset),
    .iEnable     (iEnable),
    .iACFWrite   (iACFWrite),
    .iACFAddr    (iACFAddr),
    .iACFData    (iACFData),
    .iModelWrite (iModelWrite),
    .iModelAddr  (iModelAddr),
    .iModelData  (iModelData),
    .iStart      (iStart),
    .iM          (iM),
    .iAlphaDone  (iAlphaDone),
    .oValid      (oValid),
    .oACF1       (oACF1),
    .oACF2       (oACF2),
    .oModel1     (oModel1),
    .oModel2     (oModel2),
    .oM          (oM),
    .oBusy       (oBusy),
    .oStreamDone (oStreamDone),
    .oError      (oError)
  );

  // Clock / reset
  always #5 iClock = ~iClock;

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  // Float bit patterns for small integers
  function automatic logic [31:0] f(input int n);
    case (n)
      1:  return 32'h3f80_0000;
      2:  return 32'h4000_0000;
      3:  return 32'h4040_0000;
      4:  return 32'h4080_0000;
      5:  return 32'h40a0_0000;
      6:  return 32'h40c0_0000;
      7:  return 32'h40e0_0000;
      8:  return 32'h4100_0000;
      9:  return 32'h4110_0000;
      10: return 32'h4120_0000;
      11: return 32'h4130_0000;
      12: return 32'h4140_0000;
      13: return 32'h4150_0000;
      default: return 32'h0000_0000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_beat(input logic [127:0] e, input logic [3:0] m);
    beat_t b;
    b = beat_t'(e);
    check("beat_valid",  32'(oValid), 32'd1);
    check("beat_model1", oModel1, b.m1);
    check("beat_acf2",   oACF2,   b.a2);
    check("beat_model2", oModel2, b.m2);
    check("beat_acf1",   oACF1,   b.a1);
    check("beat_m",      32'(oM), 32'(m));
    check("beat_busy",   32'(oBusy), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"},  32'(oValid), 32'd0);
    check({tag, "_model1"}, oModel1, 32'd0);
    check({tag, "_acf2"},   oACF2,   32'd0);
    check({tag, "_model2"}, oModel2, 32'd0);
    check({tag, "_acf1"},   oACF1,   32'd0);
  endtask

  // Driver tasks
  task automatic write_both(input logic [3:0] aa, input logic [31:0] ad,
                            input logic [3:0] ma, input logic [31:0] md);
    iACFWrite = 1'b1; iACFAddr = aa; iACFData = ad;
    iModelWrite = 1'b1; iModelAddr = ma; iModelData = md;
    tick();
    iACFWrite = 1'b0; iModelWrite = 1'b0;
  endtask

  // Expected beats are taken from exp_q; poke injects a start and a model
  // write during a beat, stall drops iEnable for 3 cycles after a beat.
  task automatic run_stream(input logic [3:0] m, input int nbeats,
                            input int poke, input int stall);
    logic [127:0] e;
    iStart = 1'b1; iM = m;
    tick();
    iStart = 1'b0; iM = 4'd0;
    for (int b = 0; b < nbeats; b++) begin
      if (exp_q.size() == 0) begin
        check("exp_q_empty", 32'd1, 32'd0);
        break;
      end
      e = exp_q.pop_front();
      check_beat(e, m);
      if (b == stall) begin
        iEnable = 1'b0;
        for (int j = 0; j < 3; j++) begin
          tick();
          check_beat(e, m);
        end
        iEnable = 1'b1;
      end
      if (b == poke) begin
        iStart = 1'b1; iM = 4'd2;
        iModelWrite = 1'b1; iModelAddr = 4'd1; iModelData = 32'h41f0_0000;
      end
      tick();
      iStart = 1'b0; iM = 4'd0; iModelWrite = 1'b0;
    end
    check_idle_outputs("done");
    check("done_pulse", 32'(oStreamDone), 32'd1);
    check("done_busy",  32'(oBusy), 32'd1);
    tick();
    check("wait_pulse_gone", 32'(oStreamDone), 32'd0);
    check("wait_busy",       32'(oBusy), 32'd1);
    check("wait_valid",      32'(oValid), 32'd0);
    // Start coinciding with done in S_WAIT must be dropped
    iAlphaDone = 1'b1; iStart = 1'b1; iM = 4'd3;
    tick();
    iAlphaDone = 1'b0; iStart = 1'b0; iM = 4'd0;
    check("ret_busy", 32'(oBusy), 32'd0);
    tick();
    check("ret_no_restart_valid", 32'(oValid), 32'd0);
    check("ret_no_restart_busy",  32'(oBusy), 32'd0);
  endtask

  task automatic error_start(input logic [3:0] m);
    iStart = 1'b1; iM = m;
    tick();
    iStart = 1'b0; iM = 4'd0;
    check("err_pulse", 32'(oError), 32'd1);
    check("err_busy",  32'(oBusy), 32'd0);
    check("err_valid", 32'(oValid), 32'd0);
    tick();
    check("err_pulse_end", 32'(oError), 32'd0);
    check("err_busy_after", 32'(oBusy), 32'd0);
  endtask

  initial begin
    iReset = 1'b1; iEnable = 1'b1;
    iACFWrite = 1'b0; iACFAddr = '0; iACFData = '0;
    iModelWrite = 1'b0; iModelAddr = '0; iModelData = '0;
    iStart = 1'b0; iM = '0; iAlphaDone = 1'b0;

    // Vector table: beats in the order the streams below consume them
    vecs[0]  = '{f(1),  f(4),  f(2),  f(3)};
    vecs[1]  = '{f(3),  f(2),  f(4),  f(1)};
    vecs[2]  = '{f(1),  f(5),  f(2),  f(4)};
    vecs[3]  = '{f(3),  f(3),  f(4),  f(2)};
    vecs[4]  = '{f(5),  f(1),  32'h0, 32'h0};
    vecs[5]  = '{f(1),  f(12), f(2),  f(11)};
    vecs[6]  = '{f(3),  f(10), f(4),  f(9)};
    vecs[7]  = '{f(5),  f(8),  f(6),  f(7)};
    vecs[8]  = '{f(7),  f(6),  f(8),  f(5)};
    vecs[9]  = '{f(9),  f(4),  f(10), f(3)};
    vecs[10] = '{f(11), f(2),  f(12), f(1)};
    vecs[11] = '{f(1),  f(4),  f(2),  f(3)};
    vecs[12] = '{f(3),  f(2),  f(4),  f(1)};
    vecs[13] = '{f(1),  f(2),  f(2),  f(1)};
    vecs[14] = '{f(1),  f(6),  f(2),  f(5)};
    vecs[15] = '{f(3),  f(4),  f(4),  f(3)};
    vecs[16] = '{f(5),  f(2),  f(6),  f(1)};

    streams[0] = '{4'd4,  2, -1, -1};
    streams[1] = '{4'd5,  3, -1, -1};
    streams[2] = '{4'd12, 6, -1, -1};
    streams[3] = '{4'd4,  2,  0, -1};
    streams[4] = '{4'd2,  1, -1, -1};
    streams[5] = '{4'd6,  3, -1,  1};

    tick(); tick();
    check_idle_outputs("reset");
    check("reset_m",    32'(oM), 32'd0);
    check("reset_busy", 32'(oBusy), 32'd0);
    check("reset_done", 32'(oStreamDone), 32'd0);
    check("reset_err",  32'(oError), 32'd0);
    iReset = 1'b0;
    tick();

    // m=1 minimal stream
    write_both(4'd1, 32'h3f00_0000, 4'd0, 32'h3f80_0000);
    exp_q.push_back({32'h3f80_0000, 32'h3f00_0000, 32'h0, 32'h0});
    run_stream(4'd1, 1, -1, -1);

    // ACF[k]=k, model[j]=j+1, plus out-of-range writes that must be dropped
    for (int i = 0; i <= 12; i++) write_both(4'(i), f(i), 4'(i), f(i + 1));
    write_both(4'd13, 32'hdead_beef, 4'd15, 32'hdead_beef);

    begin
      int vi;
      vi = 0;
      for (int s = 0; s < 6; s++) begin
        for (int b = 0; b < streams[s].nb; b++) begin
          exp_q.push_back(vecs[vi]);
          vi++;
        end
        run_stream(streams[s].m, streams[s].nb, streams[s].poke, streams[s].stall);
      end
    end

    error_start(4'd0);
    error_start(4'd13);

    // Reset during beat 2 of an m=8 stream
    iStart = 1'b1; iM = 4'd8;
    tick();
    iStart = 1'b0; iM = 4'd0;
    check("m8_beat0_model1", oModel1, f(1));
    tick();
    check("m8_beat1_model1", oModel1, f(3));
    tick();
    check("m8_beat2_model1", oModel1, f(5));
    check("m8_beat2_acf2",   oACF2,   f(4));
    iReset = 1'b1;
    tick();
    iReset = 1'b0;
    check_idle_outputs("rst_mid");
    check("rst_mid_busy", 32'(oBusy), 32'd0);
    check("rst_mid_m",    32'(oM), 32'd0);
    tick();
    check("rst_mid_no_beat", 32'(oValid), 32'd0);
    exp_q.push_back(128'h0);
    run_stream(4'd2, 1, -1, -1);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
